// File: rtl/frame_writer_pkg.sv
// Shared types for the convolution frame writer: pixel/word types, the FIFO
// entry layout and the Avalon write-master state encoding.
package frame_writer_pkg;

    typedef logic [15:0] pixel_t;
    typedef logic [31:0] word_t;

    // One queued write: end-of-frame marker, word index within the frame, packed pixel pair
    typedef struct packed {
        logic        last;
        logic [31:0] index;
        word_t       data;
    } fifo_entry_t;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_WRITE = 1'b1
    } wr_state_t;

    localparam int DEF_IMG_WIDTH   = 640;
    localparam int DEF_IMG_HEIGHT  = 480;
    localparam int WORDS_PER_FRAME = DEF_IMG_WIDTH * DEF_IMG_HEIGHT / 2;

    // Byte address of a 32-bit word given the frame base address
    function automatic word_t word_addr(input word_t base, input logic [31:0] index);
        return base + (index << 2);
    endfunction

endpackage

// File: rtl/frame_writer_fifo.sv
// Synchronous show-ahead FIFO of fifo_entry_t. The head entry is always
// presented on 'head'. A freshly written entry becomes visible to the read
// side one cycle after the write, so 'empty' lags a push by one cycle while
// 'full' and 'level' track the write immediately.
import frame_writer_pkg::*;

module frame_writer_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fifo_entry_t            push_data,
    input  logic                   pop,
    output fifo_entry_t            head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    fifo_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] wr_ptr_vis;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == DEPTH_L);
    assign empty   = (rd_ptr == wr_ptr_vis);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Read/write pointers; the visible write pointer trails by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            wr_ptr_vis <= '0;
            rd_ptr     <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            wr_ptr_vis <= wr_ptr;
        end
    end

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/conv_frame_writer.sv
// Frame writer: packs RGB565 pixel pairs into 32-bit words, tracks the raster
// position, queues words in a small FIFO and writes them to SDRAM through an
// Avalon-MM write-only master. A word held in the master counts against FIFO
// capacity until the slave accepts it.
// Optional feature macro: CONV_FRAME_WRITER_PERF_EN adds stall_count and
// drop_count performance counters.
import frame_writer_pkg::*;

module conv_frame_writer #(
    parameter int          IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int          IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_sync,
    input  logic [15:0] pixel_in,
    input  logic        pixel_valid,
    output logic [31:0] avm_address,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    output logic        frame_done,
    output logic        overflow
`ifdef CONV_FRAME_WRITER_PERF_EN
    ,
    output logic [31:0] stall_count,
    output logic [15:0] drop_count
`endif
);

    localparam int XW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int X_LAST_I = IMG_WIDTH - 1;
    localparam int Y_LAST_I = IMG_HEIGHT - 1;
    localparam logic [XW-1:0] X_LAST   = X_LAST_I[XW-1:0];
    localparam logic [YW-1:0] Y_LAST   = Y_LAST_I[YW-1:0];
    localparam logic [LW:0]   LVL_LAST = FIFO_DEPTH[LW:0] - 1'b1;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    pixel_t        latch;

    fifo_entry_t   push_entry;
    fifo_entry_t   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW:0]   fifo_level;
    logic          push_req;
    logic          push_ok;
    logic          drop;
    logic          occ_full;
    logic          accept;
    logic          pop;
    logic          cur_last;

    wr_state_t     state;
    wr_state_t     next_state;

    // frame_sync forces the current pixel (if any) to be (0,0) of a new frame
    assign cur_x = frame_sync ? '0 : x;
    assign cur_y = frame_sync ? '0 : y;

    assign push_req = pixel_valid && cur_x[0];
    assign accept   = (state == WR_WRITE) && !avm_waitrequest;
    // Occupancy includes the word held by the master; an acceptance this cycle frees a slot
    assign occ_full = fifo_full || ((state == WR_WRITE) && (fifo_level == LVL_LAST));
    assign push_ok  = push_req && (!occ_full || accept);
    assign drop     = push_req && !push_ok;

    assign push_entry.last  = (cur_x == X_LAST) && (cur_y == Y_LAST);
    assign push_entry.index = 32'(cur_y) * 32'(IMG_WIDTH / 2) + 32'(cur_x >> 1);
    assign push_entry.data  = {pixel_in, latch};

    assign avm_write      = (state == WR_WRITE);
    assign avm_byteenable = 4'hF;

    frame_writer_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Raster counters and even-pixel latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            latch <= '0;
        end else if (pixel_valid) begin
            if (!cur_x[0]) latch <= pixel_in;
            if (cur_x == X_LAST) begin
                x <= '0;
                y <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
            end else begin
                x <= cur_x + 1'b1;
                y <= cur_y;
            end
        end else if (frame_sync) begin
            x     <= '0;
            y     <= '0;
            latch <= '0;
        end
    end

    // Sticky overflow when a packed word could not be queued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

    // Master state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WR_IDLE;
        else       state <= next_state;
    end

    // Master next-state and FIFO pop decision
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            WR_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = WR_WRITE;
                end
            end
            WR_WRITE: begin
                if (!avm_waitrequest) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             next_state = WR_IDLE;
                end
            end
            default: next_state = WR_IDLE;
        endcase
    end

    // Address/data holding registers and end-of-frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_address   <= BASE_ADDR;
            avm_writedata <= '0;
            cur_last      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= accept && cur_last;
            if (pop) begin
                avm_address   <= word_addr(BASE_ADDR, fifo_head.index);
                avm_writedata <= fifo_head.data;
                cur_last      <= fifo_head.last;
            end
        end
    end

`ifdef CONV_FRAME_WRITER_PERF_EN
    // Stall and drop counters, restarted with each frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            drop_count  <= '0;
        end else if (frame_sync) begin
            stall_count <= '0;
            drop_count  <= '0;
        end else begin
            if (avm_write && avm_waitrequest) stall_count <= stall_count + 1'b1;
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_frame_writer.sv
// Self-checking bench for conv_frame_writer (4x2 frame, base 0x1000, FIFO depth 4).
module tb_conv_frame_writer;

    typedef struct packed {
        logic [15:0] pix;
        logic        vld;
        logic        sync;
        logic        push;
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_sync;
    logic [15:0] pixel_in;
    logic        pixel_valid;
    logic [31:0] avm_address;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_write;
    logic        avm_waitrequest;
    logic        frame_done;
    logic        overflow;
`ifdef CONV_FRAME_WRITER_PERF_EN
    logic [31:0] stall_count;
    logic [15:0] drop_count;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    logic done_exp = 1'b0;
    vec_t vecs [33];
    exp_t sb_q [$];

    always #5 clk = ~clk;

    conv_frame_writer #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (2),
        .BASE_ADDR  (32'h1000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_sync      (frame_sync),
        .pixel_in        (pixel_in),
        .pixel_valid     (pixel_valid),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .frame_done      (frame_done),
        .overflow        (overflow)
`ifdef CONV_FRAME_WRITER_PERF_EN
        ,
        .stall_count     (stall_count),
        .drop_count      (drop_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_row(input int i, input logic [15:0] pix, input logic vld, input logic sync,
                           input logic push, input logic [31:0] addr, input logic [31:0] data,
                           input logic last);
        vecs[i] = '{pix: pix, vld: vld, sync: sync, push: push, addr: addr, data: data, last: last};
    endtask

    task automatic run_rows(input int first, input int last_i);
        for (int i = first; i <= last_i; i++) begin
            @(posedge clk); #1;
            pixel_valid = vecs[i].vld;
            pixel_in    = vecs[i].pix;
            frame_sync  = vecs[i].sync;
            if (vecs[i].push) sb_q.push_back('{addr: vecs[i].addr, data: vecs[i].data, last: vecs[i].last});
        end
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        frame_sync  = 1'b0;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        pixel_valid     = 1'b0;
        frame_sync      = 1'b0;
        avm_waitrequest = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || avm_write) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {31'd0, (n < 300)}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        frame_sync      = 1'b0;
        pixel_in        = 16'h0;
        pixel_valid     = 1'b0;
        avm_waitrequest = 1'b0;

        // Stimulus table
        for (int i = 0; i < 8; i++) begin
            logic [15:0] p;
            p = 16'(i + 1);
            set_row(i, p, 1'b1, 1'b0, i[0], 32'h1000 + 32'((i / 2) * 4), {p, p - 16'd1}, (i == 7));
        end
        for (int j = 0; j < 16; j++) begin
            logic [15:0] p;
            p = 16'(16'h11 + j);
            set_row(8 + j, p, 1'b1, 1'b0, j[0] && (j < 8), 32'h1000 + 32'(((j % 8) / 2) * 4),
                    {p, p - 16'd1}, (j == 7));
        end
        set_row(24, 16'h0001, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0);
        set_row(25, 16'h0002, 1'b1, 1'b0, 1'b1, 32'h1000, 32'h0002_0001, 1'b0);
        set_row(26, 16'h0003, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0);
        set_row(27, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0,    32'h0,         1'b0);
        set_row(28, 16'hAAAA, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0);
        set_row(29, 16'hBBBB, 1'b1, 1'b0, 1'b1, 32'h1000, 32'hBBBB_AAAA, 1'b0);
        set_row(30, 16'hCCCC, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0);
        set_row(31, 16'hDDDD, 1'b1, 1'b1, 1'b0, 32'h0,    32'h0,         1'b0);
        set_row(32, 16'hEEEE, 1'b1, 1'b0, 1'b1, 32'h1000, 32'hEEEE_DDDD, 1'b0);

        fork
            begin
                #200000;
                $display("FAIL watchdog actual=timeout expected=finish");
                $fatal(1, "watchdog expired");
            end
            forever begin
                @(negedge clk);
                if (reset) begin
                    done_exp = 1'b0;
                end else begin
                    if (frame_done || done_exp) check("frame_done", {31'd0, frame_done}, {31'd0, done_exp});
                    if (frame_done) done_cnt++;
                    done_exp = 1'b0;
                    if (avm_write) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_write_addr", avm_address, 32'hFFFF_FFFF);
                        end else begin
                            check("write_addr", avm_address, sb_q[0].addr);
                            check("write_data", avm_writedata, sb_q[0].data);
                            if (!avm_waitrequest) begin
                                done_exp = sb_q[0].last;
                                void'(sb_q.pop_front());
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_write",      {31'd0, avm_write},  32'd0);
        check("rst_address",    avm_address,         32'h1000);
        check("rst_writedata",  avm_writedata,       32'h0);
        check("rst_byteenable", {28'd0, avm_byteenable}, 32'hF);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_overflow",   {31'd0, overflow},   32'd0);
        reset = 1'b0;

        // Scenario 1: one frame, no stalls, first-write latency
        done_cnt = 0;
        fork
            run_rows(0, 7);
            begin
                int k;
                k = 0;
                @(posedge clk);
                while (k < 20) begin
                    @(posedge clk); #1;
                    k++;
                    if (avm_write) break;
                end
                check("first_write_latency", k, 32'd4);
            end
        join
        wait_drain("s1_drain");
        check("s1_frame_done_count", done_cnt, 32'd1);
        check("s1_overflow", {31'd0, overflow}, 32'd0);

        // Scenario 2: five stall cycles on the first write
        do_reset();
        avm_waitrequest = 1'b1;
        fork
            run_rows(0, 7);
            begin
                int n;
                n = 0;
                while (!avm_write && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("s2_write_seen", {31'd0, avm_write}, 32'd1);
                repeat (5) @(posedge clk);
                #1 avm_waitrequest = 1'b0;
            end
        join
        wait_drain("s2_drain");
        check("s2_overflow", {31'd0, overflow}, 32'd0);
`ifdef CONV_FRAME_WRITER_PERF_EN
        check("s2_stall_count", stall_count, 32'd5);
`endif

        // Scenario 3: permanent stall, FIFO fills and later words drop
        do_reset();
        avm_waitrequest = 1'b1;
        run_rows(8, 23);
        repeat (4) @(posedge clk);
        #1;
        check("s3_overflow", {31'd0, overflow}, 32'd1);
`ifdef CONV_FRAME_WRITER_PERF_EN
        check("s3_drop_count", {16'd0, drop_count}, 32'd4);
`endif
        avm_waitrequest = 1'b0;
        wait_drain("s3_drain");
        check("s3_overflow_sticky", {31'd0, overflow}, 32'd1);
`ifdef CONV_FRAME_WRITER_PERF_EN
        frame_sync = 1'b1;
        @(posedge clk); #1;
        frame_sync = 1'b0;
        check("s3_drop_count_sync_clear", {16'd0, drop_count}, 32'd0);
`endif

        // Scenario 4: frame_sync mid-line, and frame_sync together with a pixel
        do_reset();
        run_rows(24, 32);
        wait_drain("s4_drain");
        check("s4_overflow", {31'd0, overflow}, 32'd0);

        // Scenario 5: asynchronous reset during a stalled write
        do_reset();
        avm_waitrequest = 1'b1;
        run_rows(0, 3);
        begin
            int n;
            n = 0;
            while (!avm_write && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("s5_write_before_reset", {31'd0, avm_write}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("s5_async_write_drop", {31'd0, avm_write}, 32'd0);
        do_reset();
        check("s5_post_overflow", {31'd0, overflow}, 32'd0);
        check("s5_post_address", avm_address, 32'h1000);
        check("s5_post_write", {31'd0, avm_write}, 32'd0);
        done_cnt = 0;
        run_rows(0, 7);
        wait_drain("s5_drain");
        check("s5_frame_done_count", done_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
